// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared types and width helpers for the N-to-M gearbox
package gearbox_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } gb_state_t;

    // Buffer must hold two full output words plus one incoming word
    function automatic int calc_buf_w(input int in_w, input int out_w);
        return 2 * out_w + in_w;
    endfunction

    // Fill counter must represent 0..BUF_W inclusive
    function automatic int calc_fill_w(input int in_w, input int out_w);
        return $clog2(calc_buf_w(in_w, out_w) + 1);
    endfunction

endpackage

// File: rtl/gearbox_acc.sv
// rtl/gearbox_acc.sv - LSB-aligned bit accumulator with insert/shift datapath
module gearbox_acc
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 132,
    parameter int OUT_W = 128,
    localparam int BUF_W  = calc_buf_w(IN_W, OUT_W),
    localparam int FILL_W = calc_fill_w(IN_W, OUT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_fire,
    input  logic [IN_W-1:0]   din,
    input  logic              out_fire,
    input  logic              pad,
    output logic [OUT_W-1:0]  dout,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    logic [BUF_W-1:0]  acc_q;
    logic [BUF_W-1:0]  acc_shift;
    logic [BUF_W-1:0]  acc_n;
    logic [BUF_W-1:0]  din_ext;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_shift;
    logic [FILL_W-1:0] fill_n;

    assign din_ext = {{(BUF_W - IN_W){1'b0}}, din};

    // Retire an output word first, then append the new input just above the remaining bits
    always_comb begin
        acc_shift  = out_fire ? (acc_q >> OUT_W) : acc_q;
        fill_shift = out_fire ? (fill_q - OUT_W_F) : fill_q;
        acc_n      = acc_shift;
        fill_n     = fill_shift;
        if (in_fire) begin
            acc_n  = acc_shift | (din_ext << fill_shift);
            fill_n = fill_shift + IN_W_F;
        end else if (pad) begin
            // Bits above fill are already zero, so raising fill pads with zeros
            fill_n = OUT_W_F;
        end
    end

    // Buffer and fill counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_n;
            fill_q <= fill_n;
        end
    end

    assign dout = acc_q[OUT_W-1:0];
    assign fill = fill_q;

endmodule

// File: rtl/gearbox_n_to_m.sv
// rtl/gearbox_n_to_m.sv - IN_W to OUT_W bit-stream gearbox with flush control
module gearbox_n_to_m
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 132,
    parameter int OUT_W = 128,
    localparam int FILL_W = calc_fill_w(IN_W, OUT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic [IN_W-1:0]   din,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [OUT_W-1:0]  dout,
    input  logic              dout_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [FILL_W-1:0] fill_level
);

    localparam logic [FILL_W-1:0] OUT_W_F   = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] TWO_OUT_F = FILL_W'(2 * OUT_W);

    generate
        if (IN_W < 1 || IN_W > 512 || OUT_W < 1 || OUT_W > 512) begin : g_bad_width
            $error("gearbox_n_to_m: IN_W and OUT_W must be within 1..512");
        end
    endgenerate

    gb_state_t         state_q;
    gb_state_t         state_n;
    logic [FILL_W-1:0] fill;
    logic              in_fire;
    logic              out_fire;
    logic              pad;

    // Ready/valid depend only on registered fill and state, never on dout_ready
    assign din_ready  = (fill <= TWO_OUT_F) && (state_q == RUN);
    assign dout_valid = (fill >= OUT_W_F);
    assign in_fire    = din_valid & din_ready;
    assign out_fire   = dout_valid & dout_ready;
    assign pad        = (state_q == FLUSH) && (fill != '0) && (fill < OUT_W_F) && !out_fire;
    assign flush_done = (state_q == DONE);
    assign fill_level = fill;

    gearbox_acc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_fire  (in_fire),
        .din      (din),
        .out_fire (out_fire),
        .pad      (pad),
        .dout     (dout),
        .fill     (fill)
    );

    // Flush sequencing: drain the residue, pulse done, return to normal running
    always_comb begin
        state_n = state_q;
        case (state_q)
            RUN:     if (flush) state_n = FLUSH;
            FLUSH:   if (fill == '0) state_n = DONE;
            DONE:    state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

endmodule

// File: tb/tb_gearbox_n_to_m.sv
// tb/tb_gearbox_n_to_m.sv - directed self-checking bench for gearbox_n_to_m
module tb_gearbox_n_to_m;

    localparam int IN_A  = 132;
    localparam int OUT_A = 128;
    localparam int IN_B  = 64;
    localparam int OUT_B = 66;

    logic              clk;
    logic              rst_n;

    logic              a_din_valid;
    logic [IN_A-1:0]   a_din;
    logic              a_din_ready;
    logic              a_dout_valid;
    logic [OUT_A-1:0]  a_dout;
    logic              a_dout_ready;
    logic              a_flush;
    logic              a_flush_done;
    logic [8:0]        a_fill;

    logic              b_din_valid;
    logic [IN_B-1:0]   b_din;
    logic              b_din_ready;
    logic              b_dout_valid;
    logic [OUT_B-1:0]  b_dout;
    logic              b_dout_ready;
    logic              b_flush;
    logic              b_flush_done;
    logic [7:0]        b_fill;

    int tests = 0;
    int fails = 0;

    bit qa[$];
    bit qb[$];
    int a_words = 0;
    int b_words = 0;
    int a_fd = 0;
    int a_stalls = 0;
    logic             a_prev_stall = 1'b0;
    logic [OUT_A-1:0] a_prev_dout = '0;
    logic [OUT_A-1:0] a_last = '0;
    logic [511:0]     mon_wa;
    logic [511:0]     mon_wb;

    gearbox_n_to_m u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (a_din_valid),
        .din        (a_din),
        .din_ready  (a_din_ready),
        .dout_valid (a_dout_valid),
        .dout       (a_dout),
        .dout_ready (a_dout_ready),
        .flush      (a_flush),
        .flush_done (a_flush_done),
        .fill_level (a_fill)
    );

    gearbox_n_to_m #(
        .IN_W  (IN_B),
        .OUT_W (OUT_B)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (b_din_valid),
        .din        (b_din),
        .din_ready  (b_din_ready),
        .dout_valid (b_dout_valid),
        .dout       (b_dout),
        .dout_ready (b_dout_ready),
        .flush      (b_flush),
        .flush_done (b_flush_done),
        .fill_level (b_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_A-1:0] rand_a();
        logic [IN_A-1:0] r;
        r[31:0]    = $urandom;
        r[63:32]   = $urandom;
        r[95:64]   = $urandom;
        r[127:96]  = $urandom;
        r[131:128] = 4'($urandom);
        return r;
    endfunction

    // Scoreboard for the default-width instance: bit-exact stream, hold stability, fill bound
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall)
                check("a_hold", {a_dout_valid, a_dout}, {1'b1, a_prev_dout});
            if (a_dout_valid && a_dout_ready) begin
                mon_wa = '0;
                for (int i = 0; i < OUT_A; i++)
                    if (qa.size() > 0) mon_wa[i] = qa.pop_front();
                check("a_word", a_dout, mon_wa);
                a_last = a_dout;
                a_words++;
            end
            if (a_din_valid && a_din_ready)
                for (int i = 0; i < IN_A; i++) qa.push_back(a_din[i]);
            if (a_flush_done) a_fd++;
            check("a_fill_max", a_fill <= 9'd388, 1'b1);
            a_prev_stall = a_dout_valid && !a_dout_ready;
            a_prev_dout  = a_dout;
        end
    end

    // Scoreboard for the narrow-input instance
    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_dout_valid && b_dout_ready) begin
                mon_wb = '0;
                for (int i = 0; i < OUT_B; i++)
                    if (qb.size() > 0) mon_wb[i] = qb.pop_front();
                check("b_word", b_dout, mon_wb);
                b_words++;
            end
            if (b_din_valid && b_din_ready)
                for (int i = 0; i < IN_B; i++) qb.push_back(b_din[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [IN_A-1:0] d);
        int n;
        a_din       = d;
        a_din_valid = 1'b1;
        n = 0;
        while (!a_din_ready && n < 200) begin
            a_stalls++;
            tick();
            n++;
        end
        if (n >= 200) check("a_send_timeout", 1'b0, 1'b1);
        tick();
    endtask

    task automatic send_b(input logic [IN_B-1:0] d);
        int n;
        b_din       = d;
        b_din_valid = 1'b1;
        n = 0;
        while (!b_din_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("b_send_timeout", 1'b0, 1'b1);
        tick();
    endtask

    task automatic flush_a();
        logic got;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_flush_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("a_flush_done_seen", got, 1'b1);
        tick();
    endtask

    initial begin
        int w0;
        int fd0;
        int sent;
        int cyc;
        logic acc;
        logic [IN_A-1:0] d1;
        logic [IN_A-1:0] d2;

        rst_n = 1'b0;
        a_din_valid = 1'b0; a_din = '0; a_dout_ready = 1'b0; a_flush = 1'b0;
        b_din_valid = 1'b0; b_din = '0; b_dout_ready = 1'b0; b_flush = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset values
        check("rst_din_ready", a_din_ready, 1'b1);
        check("rst_dout_valid", a_dout_valid, 1'b0);
        check("rst_dout", a_dout, '0);
        check("rst_flush_done", a_flush_done, 1'b0);
        check("rst_fill", a_fill, '0);
        check("rst_b_fill", b_fill, '0);

        // Empty flush: done pulses two cycles after the request
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("eflush_c1", a_flush_done, 1'b0);
        check("eflush_c1_ready", a_din_ready, 1'b0);
        tick();
        check("eflush_c2", a_flush_done, 1'b1);
        tick();
        check("eflush_c3", a_flush_done, 1'b0);
        check("eflush_c3_ready", a_din_ready, 1'b1);

        // Continuous stream at default widths: one stall per 33 inputs
        a_dout_ready = 1'b1;
        a_stalls = 0;
        w0 = a_words;
        for (int i = 0; i < 66; i++) send_a(rand_a());
        a_din_valid = 1'b0;
        repeat (5) tick();
        check("cont_stalls", a_stalls, 2);
        check("cont_words", a_words - w0, 68);
        check("cont_residue", a_fill, 9'd8);
        flush_a();
        check("cont_flush_words", a_words - w0, 69);
        check("cont_flush_fill", a_fill, '0);

        // Back-pressure: two inputs with dout_ready low
        a_dout_ready = 1'b0;
        w0 = a_words;
        d1 = rand_a();
        d2 = rand_a();
        send_a(d1);
        check("bp_fill1", a_fill, 9'd132);
        send_a(d2);
        a_din_valid = 1'b0;
        check("bp_fill2", a_fill, 9'd264);
        check("bp_din_ready", a_din_ready, 1'b0);
        check("bp_dout", a_dout, d1[OUT_A-1:0]);
        repeat (3) tick();
        check("bp_dout_held", a_dout, d1[OUT_A-1:0]);
        check("bp_fill_held", a_fill, 9'd264);
        a_dout_ready = 1'b1;
        repeat (4) tick();
        flush_a();
        check("bp_words", a_words - w0, 3);
        check("bp_flush_fill", a_fill, '0);

        // All-ones word then flush pads the 4-bit residue
        d1 = '1;
        send_a(d1);
        a_din_valid = 1'b0;
        repeat (3) tick();
        check("ones_fill", a_fill, 9'd4);
        check("ones_word1", a_last, {OUT_A{1'b1}});
        flush_a();
        check("ones_word2", a_last, 128'hF);
        check("ones_fill0", a_fill, '0);

        // Reset during flush with 200 bits held
        a_dout_ready = 1'b1;
        for (int i = 0; i < 18; i++) send_a(rand_a());
        a_din_valid  = 1'b0;
        a_dout_ready = 1'b0;
        check("rf_fill200", a_fill, 9'd200);
        fd0 = a_fd;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        rst_n   = 1'b0;
        check("rf_in_flush", a_din_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        check("rf_fill", a_fill, '0);
        check("rf_dout_valid", a_dout_valid, 1'b0);
        check("rf_din_ready", a_din_ready, 1'b1);
        check("rf_flush_done", a_flush_done, 1'b0);
        repeat (3) tick();
        check("rf_no_done", a_fd - fd0, 0);

        // Narrow-in / wide-out instance: 33 x 64 = 32 x 66
        b_dout_ready = 1'b1;
        for (int i = 0; i < 33; i++) send_b({$urandom, $urandom});
        b_din_valid = 1'b0;
        repeat (5) tick();
        check("b_words", b_words, 32);
        check("b_fill0", b_fill, '0);

        // Random valid/ready over 10k input words
        sent = 0;
        cyc  = 0;
        a_din        = rand_a();
        a_din_valid  = 1'($urandom % 2);
        a_dout_ready = 1'($urandom % 2);
        while (sent < 10000 && cyc < 90000) begin
            @(negedge clk);
            acc = a_din_valid && a_din_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                a_din = rand_a();
            end
            a_din_valid  = 1'($urandom % 2);
            a_dout_ready = 1'($urandom % 2);
        end
        check("rnd_sent", sent, 10000);
        a_din_valid  = 1'b0;
        a_dout_ready = 1'b1;
        repeat (5) tick();
        flush_a();
        check("rnd_fill0", a_fill, '0);
        check("rnd_queue_empty", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
